// File: rtl/marker_corner_locator.sv
// Scans a raster pixel stream for one saturated-red marker per screen quadrant and
// reports each marker's bounding-box centre once per completed frame.
module marker_corner_locator #(
  parameter int         H_ACTIVE = 800,
  parameter int         V_ACTIVE = 600,
  parameter logic [9:0] R_THR    = 10'd640,
  parameter logic [9:0] GB_THR   = 10'd256,
  parameter int         MIN_CNT  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic        o_addr_valid,
  output logic        o_found,
  output logic [19:0] o_ul_addr,
  output logic [19:0] o_ur_addr,
  output logic [19:0] o_dl_addr,
  output logic [19:0] o_dr_addr,
  output logic [1:0]  o_state
);

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  SCAN   = 2'd1;
  localparam logic [1:0]  REPORT = 2'd2;
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  H_HALF = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  V_HALF = 10'(V_ACTIVE / 2);
  localparam logic [16:0] CNT_MIN = 17'(MIN_CNT);

  logic [1:0]  state;
  logic [9:0]  row, col;
  logic [9:0]  min_row [4];
  logic [9:0]  max_row [4];
  logic [9:0]  min_col [4];
  logic [9:0]  max_col [4];
  logic [16:0] cnt     [4];
  logic [9:0]  n_min_row [4];
  logic [9:0]  n_max_row [4];
  logic [9:0]  n_min_col [4];
  logic [9:0]  n_max_col [4];
  logic [16:0] n_cnt     [4];

  logic       take, restart, last, is_marker, found_nxt;
  logic [9:0] pix_row, pix_col, nxt_row, nxt_col;
  logic [1:0] quad;
  logic       unused_bits;

  assign o_state     = state;
  assign unused_bits = &{1'b0, i_data[31:30]};

  // A frame start in IDLE or SCAN both begin a fresh frame at (0,0); REPORT ignores everything.
  assign take      = i_valid & (((state == IDLE) & i_frame_start) | (state == SCAN));
  assign restart   = take & i_frame_start;
  assign pix_row   = restart ? 10'd0 : row;
  assign pix_col   = restart ? 10'd0 : col;
  assign last      = take & (pix_row == V_LAST) & (pix_col == H_LAST);
  assign is_marker = (i_data[29:20] > R_THR) && (i_data[19:10] < GB_THR) && (i_data[9:0] < GB_THR);
  assign quad      = {pix_row >= V_HALF, pix_col >= H_HALF};

  always_comb begin
    nxt_row = pix_row;
    nxt_col = pix_col + 10'd1;
    if (pix_col == H_LAST) begin
      nxt_col = 10'd0;
      nxt_row = pix_row + 10'd1;
    end
  end

  // Accumulator values including the current pixel, so the last pixel counts in the report.
  always_comb begin
    found_nxt = 1'b1;
    for (int q = 0; q < 4; q++) begin
      n_min_row[q] = restart ? 10'h3ff : min_row[q];
      n_max_row[q] = restart ? 10'h000 : max_row[q];
      n_min_col[q] = restart ? 10'h3ff : min_col[q];
      n_max_col[q] = restart ? 10'h000 : max_col[q];
      n_cnt[q]     = restart ? 17'd0   : cnt[q];
      if (take && is_marker && (quad == q[1:0])) begin
        if (pix_row < n_min_row[q]) n_min_row[q] = pix_row;
        if (pix_row > n_max_row[q]) n_max_row[q] = pix_row;
        if (pix_col < n_min_col[q]) n_min_col[q] = pix_col;
        if (pix_col > n_max_col[q]) n_max_col[q] = pix_col;
        if (n_cnt[q] != 17'h1ffff) n_cnt[q] = n_cnt[q] + 17'd1;
      end
      if (n_cnt[q] < CNT_MIN) found_nxt = 1'b0;
    end
  end

  function automatic logic [9:0] mid(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10:1];
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      row          <= 10'd0;
      col          <= 10'd0;
      o_addr_valid <= 1'b0;
      o_found      <= 1'b0;
      o_ul_addr    <= 20'd0;
      o_ur_addr    <= 20'd0;
      o_dl_addr    <= 20'd0;
      o_dr_addr    <= 20'd0;
      for (int q = 0; q < 4; q++) begin
        min_row[q] <= 10'h3ff;
        max_row[q] <= 10'h000;
        min_col[q] <= 10'h3ff;
        max_col[q] <= 10'h000;
        cnt[q]     <= 17'd0;
      end
    end else begin
      o_addr_valid <= 1'b0;
      case (state)
        IDLE, SCAN: begin
          if (take) begin
            if (last) begin
              state        <= REPORT;
              row          <= 10'd0;
              col          <= 10'd0;
              o_addr_valid <= 1'b1;
              o_found      <= found_nxt;
              if (found_nxt) begin
                o_ul_addr <= {mid(n_min_row[0], n_max_row[0]), mid(n_min_col[0], n_max_col[0])};
                o_ur_addr <= {mid(n_min_row[1], n_max_row[1]), mid(n_min_col[1], n_max_col[1])};
                o_dl_addr <= {mid(n_min_row[2], n_max_row[2]), mid(n_min_col[2], n_max_col[2])};
                o_dr_addr <= {mid(n_min_row[3], n_max_row[3]), mid(n_min_col[3], n_max_col[3])};
              end
              for (int q = 0; q < 4; q++) begin
                min_row[q] <= 10'h3ff;
                max_row[q] <= 10'h000;
                min_col[q] <= 10'h3ff;
                max_col[q] <= 10'h000;
                cnt[q]     <= 17'd0;
              end
            end else begin
              state <= SCAN;
              row   <= nxt_row;
              col   <= nxt_col;
              for (int q = 0; q < 4; q++) begin
                min_row[q] <= n_min_row[q];
                max_row[q] <= n_max_row[q];
                min_col[q] <= n_min_col[q];
                max_col[q] <= n_max_col[q];
                cnt[q]     <= n_cnt[q];
              end
            end
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_marker_corner_locator.sv
// Bench for marker_corner_locator on a reduced 64x48 raster; expectations come from a
// queue of marker coordinates reduced to per-quadrant bounding boxes at frame end.
module tb_marker_corner_locator;

  localparam int H = 64;
  localparam int V = 48;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_frame_start;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_addr_valid;
  logic        o_found;
  logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
  logic [1:0]  o_state;

  marker_corner_locator #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_valid(i_valid),
    .i_data(i_data), .o_addr_valid(o_addr_valid), .o_found(o_found),
    .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr), .o_dl_addr(o_dl_addr),
    .o_dr_addr(o_dr_addr), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  always @(negedge i_clk) if (o_addr_valid === 1'b1) strobe_cnt++;

  // Frame description: one rectangular block per quadrant plus optional random noise.
  int          blk_r0 [4];
  int          blk_c0 [4];
  int          blk_h  [4];
  int          blk_w  [4];
  logic [31:0] blk_val [4];
  bit          noise_on;

  // Reference model state.
  int          mk_q [$];
  int          mk_r [$];
  int          mk_c [$];
  logic        exp_found;
  logic [19:0] exp_addr [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] marker_val(input int r, input int g, input int b);
    return {2'b0, 10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic bit ref_marker(input logic [31:0] d);
    return (int'(d[29:20]) > 640) && (int'(d[19:10]) < 256) && (int'(d[9:0]) < 256);
  endfunction

  function automatic logic [31:0] pixel_at(input int r, input int c);
    logic [31:0] x;
    for (int q = 0; q < 4; q++)
      if (r >= blk_r0[q] && r < blk_r0[q] + blk_h[q] && c >= blk_c0[q] && c < blk_c0[q] + blk_w[q])
        return blk_val[q];
    x = 32'h0;
    if (noise_on && $urandom_range(0, 7) == 0) begin
      x = $urandom;
      x[31:30] = 2'b00;
    end
    return x;
  endfunction

  task automatic set_block(input int q, input int r0, input int c0, input int h, input int w,
                           input logic [31:0] v);
    blk_r0[q] = r0; blk_c0[q] = c0; blk_h[q] = h; blk_w[q] = w; blk_val[q] = v;
  endtask

  task automatic directed_blocks();
    for (int q = 0; q < 4; q++)
      set_block(q, (q < 2) ? 10 : 30, (q % 2 == 0) ? 5 : 50, 4, 4, marker_val(1023, 0, 0));
  endtask

  task automatic rand_blocks();
    int h, w, r0, c0;
    for (int q = 0; q < 4; q++) begin
      h  = $urandom_range(3, 6);
      w  = $urandom_range(3, 6);
      r0 = (q < 2) ? $urandom_range(0, V / 2 - h) : $urandom_range(V / 2, V - h);
      c0 = (q % 2 == 0) ? $urandom_range(0, H / 2 - w) : $urandom_range(H / 2, H - w);
      set_block(q, r0, c0, h, w, marker_val($urandom_range(641, 1023), $urandom_range(0, 255),
                                             $urandom_range(0, 255)));
    end
  endtask

  task automatic model_expect();
    int cnt [4];
    int mnr [4];
    int mxr [4];
    int mnc [4];
    int mxc [4];
    for (int q = 0; q < 4; q++) begin
      cnt[q] = 0; mnr[q] = 1023; mxr[q] = 0; mnc[q] = 1023; mxc[q] = 0;
    end
    foreach (mk_q[i]) begin
      cnt[mk_q[i]]++;
      if (mk_r[i] < mnr[mk_q[i]]) mnr[mk_q[i]] = mk_r[i];
      if (mk_r[i] > mxr[mk_q[i]]) mxr[mk_q[i]] = mk_r[i];
      if (mk_c[i] < mnc[mk_q[i]]) mnc[mk_q[i]] = mk_c[i];
      if (mk_c[i] > mxc[mk_q[i]]) mxc[mk_q[i]] = mk_c[i];
    end
    exp_found = 1'b1;
    for (int q = 0; q < 4; q++) if (cnt[q] < 16) exp_found = 1'b0;
    if (exp_found)
      for (int q = 0; q < 4; q++) exp_addr[q] = {10'((mnr[q] + mxr[q]) / 2), 10'((mnc[q] + mxc[q]) / 2)};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      i_valid = 1'b0;
      i_frame_start = 1'b0;
      i_data = $urandom;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive_pixel(input bit fs, input logic [31:0] d);
    i_frame_start = fs;
    i_valid = 1'b1;
    i_data = d;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_found"}, o_found, exp_found);
    check({tag, "_ul"}, o_ul_addr, exp_addr[0]);
    check({tag, "_ur"}, o_ur_addr, exp_addr[1]);
    check({tag, "_dl"}, o_dl_addr, exp_addr[2]);
    check({tag, "_dr"}, o_dr_addr, exp_addr[3]);
  endtask

  // Drives a frame from (0,0); stop_at >= 0 abandons it just before that raster index.
  task automatic run_frame(input string tag, input bit half_valid, input int stop_at);
    int s0;
    logic [31:0] d;
    s0 = strobe_cnt;
    mk_q.delete(); mk_r.delete(); mk_c.delete();
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        if (stop_at >= 0 && r * H + c == stop_at) begin
          check({tag, "_no_strobe_partial"}, strobe_cnt, s0);
          return;
        end
        if (half_valid) idle(1);
        d = pixel_at(r, c);
        drive_pixel(r == 0 && c == 0, d);
        if (ref_marker(d)) begin
          mk_q.push_back(((r >= V / 2) ? 2 : 0) + ((c >= H / 2) ? 1 : 0));
          mk_r.push_back(r);
          mk_c.push_back(c);
        end
      end
    end
    check({tag, "_early_strobe"}, strobe_cnt, s0);
    check({tag, "_strobe"}, o_addr_valid, 1'b1);
    model_expect();
    check_outputs(tag);
    idle(1);
    check({tag, "_strobe_width"}, o_addr_valid, 1'b0);
    check({tag, "_strobe_count"}, strobe_cnt, s0 + 1);
    idle(2);
  endtask

  initial begin
    int s0;
    i_rst = 1'b1;
    i_frame_start = 1'b0;
    i_valid = 1'b0;
    i_data = 32'h0;
    noise_on = 1'b0;
    exp_found = 1'b0;
    for (int q = 0; q < 4; q++) begin
      exp_addr[q] = 20'd0;
      set_block(q, 0, 0, 0, 0, 32'h0);
    end
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", o_addr_valid, 1'b0);
    check("rst_state", o_state, 2'd0);
    check_outputs("rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(2);

    run_frame("black", 1'b0, -1);

    directed_blocks();
    run_frame("blocks", 1'b0, -1);
    check("blocks_ul_const", o_ul_addr, {10'd11, 10'd6});

    set_block(3, 30, 50, 3, 3, marker_val(1023, 0, 0));
    run_frame("small_dr", 1'b0, -1);

    directed_blocks();
    run_frame("half_valid", 1'b1, -1);

    for (int k = 0; k < 3; k++) begin
      rand_blocks();
      noise_on = (k == 2);
      run_frame($sformatf("rand%0d", k), 1'b0, -1);
    end
    noise_on = 1'b0;

    s0 = strobe_cnt;
    rand_blocks();
    run_frame("abort", 1'b0, (V / 2) * H);
    rand_blocks();
    run_frame("restart", 1'b0, -1);
    check("restart_one_strobe", strobe_cnt, s0 + 1);

    directed_blocks();
    run_frame("pre_rst", 1'b0, -1);
    run_frame("rst_mid", 1'b0, (V / 2) * H + 7);
    i_rst = 1'b1;
    #1;
    exp_found = 1'b0;
    for (int q = 0; q < 4; q++) exp_addr[q] = 20'd0;
    check("midrst_state", o_state, 2'd0);
    check_outputs("midrst");
    @(negedge i_clk);
    i_rst = 1'b0;
    s0 = strobe_cnt;
    for (int i = 0; i < 3 * H; i++) drive_pixel(1'b0, marker_val(1023, 0, 0));
    idle(2);
    check("midrst_ignored_strobe", strobe_cnt, s0);
    check("midrst_ignored_state", o_state, 2'd0);

    set_block(3, 30, 50, 6, 6, marker_val(640, 0, 0));
    run_frame("r_at_thr", 1'b0, -1);
    check("r_at_thr_found_const", o_found, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
